// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: up/down tap index counter over 0..MAX_CNT with free-run wrap
// or one-shot sweep handshake, plus a counter of completed wraps/sweeps.
module fir_tap_sequencer #(
    parameter int MAX_CNT = 64,
    parameter int CNT_W   = 7,
    parameter int OUT_W   = 6,
    parameter int WRAP_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cnt_en,
    input  logic              dir,
    input  logic              one_shot,
    input  logic              start,
    input  logic              clear,
    input  logic              load,
    input  logic [CNT_W-1:0]  load_val,
    output logic [OUT_W-1:0]  out_cnt,
    output logic              cout,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] TOP = CNT_W'(MAX_CNT);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, s_val;
    logic [WRAP_W-1:0] wrap_nxt;
    logic dir_q, dir_q_nxt, dir_eff, counting;
    // a sweep keeps the direction it started with
    assign dir_eff  = (state == RUN) ? dir_q : dir;
    assign s_val    = dir_eff ? TOP : '0;
    assign cout     = cnt == (dir_eff ? '0 : TOP);
    assign counting = cnt_en && (state == RUN || (state == IDLE && !one_shot));
    assign out_cnt  = cnt[OUT_W-1:0];
    assign busy     = state == RUN;
    assign done     = state == DONE;
    always_comb begin
        state_nxt = (state == DONE) ? IDLE : state;
        cnt_nxt   = cnt;
        wrap_nxt  = wrap_cnt;
        dir_q_nxt = dir_q;
        if (clear) begin
            cnt_nxt   = '0;
            wrap_nxt  = '0;
            state_nxt = IDLE;
        end else if (load) begin
            cnt_nxt = (load_val > TOP) ? TOP : load_val;
        end else if (state == IDLE && one_shot && start) begin
            cnt_nxt   = s_val;
            dir_q_nxt = dir;
            state_nxt = RUN;
        end else if (counting) begin
            if (cout) begin
                cnt_nxt  = s_val;
                wrap_nxt = wrap_cnt + 1'b1;
                if (state == RUN) state_nxt = DONE;
            end else begin
                cnt_nxt = dir_eff ? cnt - 1'b1 : cnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wrap_cnt <= '0;
            dir_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wrap_cnt <= wrap_nxt;
            dir_q    <= dir_q_nxt;
        end
    end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed scenarios plus random stimulus, every cycle
// compared against an integer sweep model of the tap sequencer.
module tb_fir_tap_sequencer;
    localparam int MAXC = 64;
    logic clock = 1'b0, reset = 1'b1;
    logic cnt_en = 0, dir = 0, one_shot = 0, start = 0, clear = 0, load = 0;
    logic [6:0] load_val = '0;
    logic [5:0] out_cnt;
    logic cout, busy, done;
    logic [7:0] wrap_cnt;
    int checks = 0, errors = 0;
    int m_cnt, m_wrap;
    bit m_run, m_done, m_dirq;

    fir_tap_sequencer dut (
        .clock(clock), .reset(reset), .cnt_en(cnt_en), .dir(dir), .one_shot(one_shot),
        .start(start), .clear(clear), .load(load), .load_val(load_val),
        .out_cnt(out_cnt), .cout(cout), .busy(busy), .done(done), .wrap_cnt(wrap_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0; m_wrap = 0; m_run = 0; m_done = 0; m_dirq = 0;
    endtask

    task automatic check_all(input string tag);
        bit de;
        de = m_run ? m_dirq : dir;
        chk({tag, "_cnt"}, 32'(out_cnt), 32'(m_cnt % 64));
        chk({tag, "_cout"}, 32'(cout), 32'(m_cnt == (de ? 0 : MAXC)));
        chk({tag, "_busy"}, 32'(busy), 32'(m_run));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_wrap"}, 32'(wrap_cnt), 32'(m_wrap));
    endtask

    // reference: one clock edge of the sequencer, in terms of sweeps and integers
    task automatic step();
        bit was_done, de;
        int s, term;
        was_done = m_done;
        de = m_run ? m_dirq : dir;
        s = de ? MAXC : 0;
        term = de ? 0 : MAXC;
        m_done = 0;
        if (clear) begin
            m_cnt = 0; m_wrap = 0; m_run = 0;
        end else if (load) begin
            m_cnt = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
        end else if (!m_run && !was_done && one_shot && start) begin
            m_cnt = s; m_dirq = dir; m_run = 1;
        end else if (cnt_en && (m_run || (!was_done && !one_shot))) begin
            if (m_cnt == term) begin
                m_cnt = s;
                m_wrap = (m_wrap + 1) % 256;
                if (m_run) begin m_run = 0; m_done = 1; end
            end else begin
                m_cnt += de ? -1 : 1;
            end
        end
    endtask

    task automatic cyc(input bit en, input bit d, input bit os, input bit st, input bit cl,
                       input bit ld, input int lv, input string tag);
        cnt_en = en; dir = d; one_shot = os; start = st; clear = cl; load = ld;
        load_val = 7'(lv);
        #1;
        check_all(tag);
        @(posedge clock);
        step();
        @(negedge clock);
    endtask

    task automatic sweep(input bit half, input bit noisy, input string tag);
        int b;
        b = 0;
        cyc(0, 0, 1, 1, 0, 0, 0, {tag, "_start"});
        for (int i = 0; i < 400 && !done; i++) begin
            if (busy) b++;
            cyc(half ? bit'(i % 2) : 1'b1, noisy ? 1'($urandom) : 1'b0, 1, noisy, 0, 0, 0, tag);
        end
        chk({tag, "_busy_cycles"}, b, half ? 130 : 65);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_end_cnt"}, 32'(out_cnt), 0);
        chk({tag, "_wrap"}, 32'(wrap_cnt), 1);
        cyc(0, 0, 1, 0, 0, 0, 0, {tag, "_after"});
        chk({tag, "_done_gone"}, 32'(done), 0);
    endtask

    initial begin
        m_reset();
        @(negedge clock);
        chk("rst_cnt", 32'(out_cnt), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wrap", 32'(wrap_cnt), 0);
        reset = 0;
        // free-running up
        repeat (64) cyc(1, 0, 0, 0, 0, 0, 0, "t1");
        chk("t1_top_cout", 32'(cout), 1);
        cyc(1, 0, 0, 0, 0, 0, 0, "t1");
        chk("t1_wrap", 32'(wrap_cnt), 1);
        chk("t1_wrapped_cnt", 32'(out_cnt), 0);
        // free-running down through zero
        cyc(0, 0, 0, 0, 1, 0, 0, "t2_clr");
        cyc(0, 0, 0, 0, 0, 1, 3, "t2_ld");
        repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, "t2");
        chk("t2_zero_cout", 32'(cout), 1);
        cyc(1, 1, 0, 0, 0, 0, 0, "t2");
        chk("t2_top_cnt", 32'(out_cnt), 0);
        chk("t2_top_cout", 32'(cout), 0);
        chk("t2_wrap", 32'(wrap_cnt), 1);
        cyc(1, 1, 0, 0, 0, 0, 0, "t2");
        chk("t2_63", 32'(out_cnt), 63);
        // one-shot sweeps, full rate and half rate
        cyc(0, 0, 1, 0, 1, 0, 0, "t3_clr");
        sweep(0, 0, "t3a");
        cyc(0, 0, 1, 0, 1, 0, 0, "t3_clr");
        sweep(1, 0, "t3b");
        // saturating load and load beating count
        cyc(0, 0, 0, 0, 0, 1, 100, "t4_ld");
        chk("t4_sat_cnt", 32'(out_cnt), 0);
        chk("t4_sat_cout", 32'(cout), 1);
        cyc(1, 0, 0, 0, 0, 1, 5, "t4_ld_en");
        chk("t4_no_inc", 32'(out_cnt), 5);
        // async reset in the middle of a sweep
        cyc(0, 0, 1, 1, 0, 0, 0, "t5_start");
        repeat (30) cyc(1, 0, 1, 0, 0, 0, 0, "t5");
        chk("t5_mid_cnt", 32'(out_cnt), 30);
        #2 reset = 1;
        #1;
        chk("t5_async_cnt", 32'(out_cnt), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_done", 32'(done), 0);
        chk("t5_async_wrap", 32'(wrap_cnt), 0);
        @(negedge clock);
        reset = 0;
        m_reset();
        cyc(1, 0, 1, 0, 0, 0, 0, "t5_idle");
        chk("t5_held", 32'(out_cnt), 0);
        // clear beats load and start; start during a sweep is ignored
        cyc(1, 0, 1, 0, 0, 1, 20, "t6_pre");
        cyc(1, 0, 1, 1, 1, 1, 20, "t6_all");
        chk("t6_clr_cnt", 32'(out_cnt), 0);
        chk("t6_clr_busy", 32'(busy), 0);
        sweep(0, 1, "t6");
        // random stimulus against the model
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(99) < 75, $urandom_range(99) < 40, $urandom_range(99) < 50,
                $urandom_range(99) < 10, $urandom_range(99) < 2, $urandom_range(99) < 4,
                $urandom_range(127), "rnd");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
